// File: rtl/mem_stage_if.sv
// Pipeline-side signals of the memory stage: EX->MEM bus, stall vector,
// SRAM read data, MEM->WB bus and the MEM forwarding port into ID.
interface mem_stage_if #(
  parameter int EX_TO_MEM_WD = 79,
  parameter int MEM_TO_WB_WD = 70
);
  logic [5:0]              stall;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [31:0]             data_sram_rdata;
  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
  logic                    mem_wreg;
  logic [4:0]              mem_waddr;
  logic [31:0]             mem_wdata;

  modport master (
    output stall, ex_to_mem_bus, data_sram_rdata,
    input  mem_to_wb_bus, mem_wreg, mem_waddr, mem_wdata
  );

  modport slave (
    input  stall, ex_to_mem_bus, data_sram_rdata,
    output mem_to_wb_bus, mem_wreg, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: registers the EX->MEM bus, extends load data from the
// synchronous data SRAM, and holds that data while WB is stalled.
module mem_stage #(
  parameter int EX_TO_MEM_WD = 79,
  parameter int MEM_TO_WB_WD = 70
) (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  mif
);

  localparam logic [2:0] LD_NONE = 3'b000;
  localparam logic [2:0] LD_LB   = 3'b001;
  localparam logic [2:0] LD_LBU  = 3'b010;
  localparam logic [2:0] LD_LH   = 3'b011;
  localparam logic [2:0] LD_LHU  = 3'b100;

  logic [EX_TO_MEM_WD-1:0] bus_q, bus_d;
  logic                    hold_vld_q, hold_vld_d;
  logic [31:0]             hold_data_q, hold_data_d;

  logic        stall_mem, stall_wb;
  logic [31:0] pc;
  logic [2:0]  ld_op;
  logic        data_ram_en;
  logic [3:0]  data_ram_wen;
  logic        sel_rf_res;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] ex_result;
  logic [1:0]  off;
  logic [31:0] rdata_eff;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_value;
  logic [31:0] rf_wdata;
  logic        unused_bits;

  assign stall_mem = mif.stall[3];
  assign stall_wb  = mif.stall[4];

  // A stalled MEM with a running WB sends a bubble downstream.
  always_comb begin
    bus_d = bus_q;
    if (rst) begin
      bus_d = '0;
    end else if (stall_mem && !stall_wb) begin
      bus_d = '0;
    end else if (!stall_mem) begin
      bus_d = mif.ex_to_mem_bus;
    end
  end

  // SRAM data is only valid one cycle, so grab it on the first WB stall edge.
  always_comb begin
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    if (rst) begin
      hold_vld_d  = 1'b0;
      hold_data_d = '0;
    end else if (!stall_wb) begin
      hold_vld_d  = 1'b0;
    end else if (!hold_vld_q) begin
      hold_vld_d  = 1'b1;
      hold_data_d = mif.data_sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    bus_q       <= bus_d;
    hold_vld_q  <= hold_vld_d;
    hold_data_q <= hold_data_d;
  end

  assign pc           = bus_q[78:47];
  assign ld_op        = bus_q[46:44];
  assign data_ram_en  = bus_q[43];
  assign data_ram_wen = bus_q[42:39];
  assign sel_rf_res   = bus_q[38];
  assign rf_we        = bus_q[37];
  assign rf_waddr     = bus_q[36:32];
  assign ex_result    = bus_q[31:0];
  assign off          = ex_result[1:0];

  assign rdata_eff = hold_vld_q ? hold_data_q : mif.data_sram_rdata;

  always_comb begin
    ld_byte = rdata_eff[7:0];
    case (off)
      2'd1:    ld_byte = rdata_eff[15:8];
      2'd2:    ld_byte = rdata_eff[23:16];
      2'd3:    ld_byte = rdata_eff[31:24];
      default: ld_byte = rdata_eff[7:0];
    endcase
  end

  // Halfword alignment is checked elsewhere; off[0] is don't-care here.
  assign ld_half = off[1] ? rdata_eff[31:16] : rdata_eff[15:0];

  always_comb begin
    load_value = rdata_eff;
    case (ld_op)
      LD_LB:   load_value = {{24{ld_byte[7]}}, ld_byte};
      LD_LBU:  load_value = {24'd0, ld_byte};
      LD_LH:   load_value = {{16{ld_half[15]}}, ld_half};
      LD_LHU:  load_value = {16'd0, ld_half};
      default: load_value = rdata_eff;
    endcase
  end

  assign rf_wdata = (sel_rf_res && data_ram_en && (ld_op != LD_NONE)) ? load_value : ex_result;

  assign mif.mem_to_wb_bus = {pc, rf_we, rf_waddr, rf_wdata};
  assign mif.mem_wreg      = rf_we;
  assign mif.mem_waddr     = rf_waddr;
  assign mif.mem_wdata     = rf_wdata;

  assign unused_bits = ^{data_ram_wen, mif.stall[5], mif.stall[2:0]};

endmodule

// File: tb/tb_mem_stage.sv
// Randomised bench for mem_stage with a behavioural model and directed
// hand-computed cases for reset, ALU passthrough, load extension, stall and bubble.
module tb_mem_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_stage_if #(.EX_TO_MEM_WD(79), .MEM_TO_WB_WD(70)) mif ();

  mem_stage #(.EX_TO_MEM_WD(79), .MEM_TO_WB_WD(70)) dut (
    .clk (clk),
    .rst (rst),
    .mif (mif)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: the instruction sitting in MEM and the data word captured at the
  // start of a WB stall (if any).
  logic [78:0] m_bus;
  logic        m_hold_vld;
  logic [31:0] m_hold_data;
  bit          m_valid = 1'b0;

  function automatic logic [78:0] mk(input logic [31:0] pc, input logic [2:0] ld,
                                     input logic en, input logic [3:0] wen, input logic sel,
                                     input logic we, input logic [4:0] wa, input logic [31:0] res);
    return {pc, ld, en, wen, sel, we, wa, res};
  endfunction

  function automatic logic [31:0] exp_wdata();
    logic [2:0]  ld;
    logic [31:0] res, rd, v;
    int          sh;
    ld  = m_bus[46:44];
    res = m_bus[31:0];
    rd  = m_hold_vld ? m_hold_data : mif.data_sram_rdata;
    if (!(m_bus[38] && m_bus[43] && ld != 3'd0)) return res;
    sh = 8 * int'(res[1:0]);
    case (ld)
      3'd1, 3'd2: begin
        v = (rd >> sh) & 32'hFF;
        if (ld == 3'd1 && v >= 32'd128) v = v - 32'd256;
      end
      3'd3, 3'd4: begin
        v = (rd >> (res[1] ? 16 : 0)) & 32'hFFFF;
        if (ld == 3'd3 && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_bus      = '0;
      m_hold_vld = 1'b0;
      m_valid    = 1'b1;
    end else begin
      if (mif.stall[4]) begin
        if (!m_hold_vld) begin
          m_hold_data = mif.data_sram_rdata;
          m_hold_vld  = 1'b1;
        end
      end else begin
        m_hold_vld = 1'b0;
      end
      if (!mif.stall[3])     m_bus = mif.ex_to_mem_bus;
      else if (!mif.stall[4]) m_bus = '0;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("wb_bus", mif.mem_to_wb_bus, {m_bus[78:47], m_bus[37], m_bus[36:32], exp_wdata()});
      chk("fwd", {32'd0, mif.mem_wreg, mif.mem_waddr, mif.mem_wdata},
          {32'd0, m_bus[37], m_bus[36:32], exp_wdata()});
    end
  end

  task automatic step(input logic r, input logic [5:0] s, input logic [78:0] b, input logic [31:0] rd);
    rst                 = r;
    mif.stall           = s;
    mif.ex_to_mem_bus   = b;
    mif.data_sram_rdata = rd;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  logic [2:0]  ld_tab  [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
  logic [1:0]  off_tab [5] = '{2'd3, 2'd2, 2'd2, 2'd0, 2'd0};
  logic [31:0] exp_tab [5] = '{32'hFFFF_FF80, 32'h0000_00FF, 32'hFFFF_80FF,
                               32'h0000_7F01, 32'h80FF_7F01};

  initial begin
    logic [78:0] b_rst, b_lw, b_nx;
    logic [95:0] rnd;
    logic [5:0]  s;
    int          v;

    b_rst = mk(32'h0000_0040, 3'd0, 1'b0, 4'd0, 1'b0, 1'b1, 5'd3, 32'hCAFE_0001);
    step(1'b1, 6'd0, b_rst, 32'd0);
    chk("rst_wb0", mif.mem_to_wb_bus, 70'd0);
    step(1'b1, 6'd0, b_rst, 32'd0);
    chk("rst_wb1", mif.mem_to_wb_bus, 70'd0);
    step(1'b0, 6'd0, b_rst, 32'd0);
    chk("rst_release", mif.mem_to_wb_bus, {32'h0000_0040, 1'b1, 5'd3, 32'hCAFE_0001});

    step(1'b0, 6'd0, mk(32'h100, 3'd0, 1'b0, 4'd0, 1'b0, 1'b1, 5'd5, 32'h1234_5678), 32'hFFFF_FFFF);
    chk("alu_fwd", {32'd0, mif.mem_wreg, mif.mem_waddr, mif.mem_wdata}, {32'd0, 1'b1, 5'd5, 32'h1234_5678});

    for (int i = 0; i < 5; i++) begin
      step(1'b0, 6'd0, mk(32'h200 + 32'(i), ld_tab[i], 1'b1, 4'd0, 1'b1, 1'b1, 5'd7,
                          32'h0000_2000 | {30'd0, off_tab[i]}), 32'h80FF_7F01);
      chk($sformatf("load_%0d", ld_tab[i]), {38'd0, mif.mem_wdata}, {38'd0, exp_tab[i]});
    end

    b_lw = mk(32'h300, 3'd5, 1'b1, 4'd0, 1'b1, 1'b1, 5'd9, 32'h0000_3000);
    b_nx = mk(32'h304, 3'd0, 1'b0, 4'd0, 1'b0, 1'b1, 5'd10, 32'h0000_0077);
    step(1'b0, 6'd0, b_lw, 32'hDEAD_BEEF);
    chk("hold_pre", {38'd0, mif.mem_wdata}, {38'd0, 32'hDEAD_BEEF});
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 6'b011111, b_nx, (i == 0) ? 32'hDEAD_BEEF : 32'd0);
      mif.data_sram_rdata = 32'd0;
      #1;
      chk("hold_stall", {38'd0, mif.mem_wdata}, {38'd0, 32'hDEAD_BEEF});
    end
    mif.stall = 6'd0;
    #1;
    chk("hold_release", {38'd0, mif.mem_wdata}, {38'd0, 32'hDEAD_BEEF});
    step(1'b0, 6'd0, b_nx, 32'd0);
    chk("after_release", {38'd0, mif.mem_wdata}, {38'd0, 32'h0000_0077});

    step(1'b0, 6'b001111, mk(32'h400, 3'd0, 1'b0, 4'd0, 1'b0, 1'b1, 5'd11, 32'h1111_2222), 32'd0);
    chk("bubble_wb", mif.mem_to_wb_bus, 70'd0);
    chk("bubble_wreg", {69'd0, mif.mem_wreg}, 70'd0);

    step(1'b0, 6'd0, mk(32'h500, 3'd1, 1'b1, 4'd0, 1'b1, 1'b1, 5'd4, 32'h0000_0101), 32'h0000_8000);
    chk("lb_pre", {38'd0, mif.mem_wdata}, {38'd0, 32'hFFFF_FF80});
    step(1'b0, 6'b011111, b_nx, 32'h0000_8000);
    step(1'b1, 6'b011111, b_nx, 32'd0);
    chk("rst_stall", mif.mem_to_wb_bus, 70'd0);
    step(1'b0, 6'd0, mk(32'h600, 3'd5, 1'b1, 4'd0, 1'b1, 1'b1, 5'd2, 32'h0000_0010), 32'd0);
    mif.data_sram_rdata = 32'h55AA_33CC;
    #1;
    chk("rst_resume", {38'd0, mif.mem_wdata}, {38'd0, 32'h55AA_33CC});

    for (int i = 0; i < 3000; i++) begin
      rnd = {$urandom, $urandom, $urandom};
      v = $urandom_range(0, 9);
      if (v < 5)       s = 6'b000000;
      else if (v == 5) s = 6'b000111;
      else if (v == 6) s = 6'b001111;
      else if (v < 9)  s = 6'b011111;
      else             s = 6'b111111;
      step(($urandom_range(0, 63) == 0), s, rnd[78:0], $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
